uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from a producer (CPU bus, button logic, test pattern generator) at full clock rate and stores them in a circular FIFO. It drains the FIFO one byte at a time into the transmitter through the transmitter's `write_en_i`/`byte_i`/`busy_o` handshake. Producers never have to track transmitter timing.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Must be a power of two and ≥ 2.
- `LVL_W`, `$clog2(DEPTH)+1`: width of the level count. Derived; do not override.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` in 1: system clock, shared with the transmitter.
- `reset_i` in 1: asynchronous, active-high reset.
- `wr_en_i` in 1: push request. Sampled on the rising edge.
- `wr_data_i` in 8: byte to push.
- `full_o` out 1: FIFO holds `DEPTH` bytes.
- `empty_o` out 1: FIFO holds 0 bytes.
- `level_o` out `LVL_W`: current occupancy, 0..`DEPTH`.
- `tx_write_en_o` out 1: connects to transmitter `write_en_i`. High for exactly one cycle per byte.
- `tx_byte_o` out 8: connects to transmitter `byte_i`. Stable from the launch cycle until the next pop.
- `tx_busy_i` in 1: connects to transmitter `busy_o`.
- `overflow_o` out 1: only present when the macro is defined (see Configuration).
- `ovf_clr_i` in 1: only present when the macro is defined (see Configuration).

## Operation
Storage:
- Write and read pointers are `$clog2(DEPTH)+1` bits wide, with the MSB used as a wrap bit.
- `empty_o` is true when the pointers are equal.
- `full_o` is true when the index bits are equal and the MSBs differ.
- `level_o` = `wr_ptr - rd_ptr`, computed modulo 2^`LVL_W`.
- Pointers wrap naturally from `DEPTH-1` to 0.

Push:
- A push is accepted when `wr_en_i` && !`full_o`. The byte is written at `wr_ptr` and `wr_ptr` increments.
- A push while `full_o` is dropped. The data and pointers are unchanged.
- `full_o` reflects the pre-edge state. A push in the same cycle as a pop while full is still dropped.

Drain FSM (state register of type `tx_fifo_state_e`):
- `S_IDLE`: if !`empty_o` && !`tx_busy_i`, then register `mem[rd_ptr]` into `tx_byte_o`, increment `rd_ptr`, and go to `S_LAUNCH`. Otherwise stay.
- `S_LAUNCH`: `tx_write_en_o` = 1. Go to `S_WAIT_BUSY` unconditionally.
- `S_WAIT_BUSY`: stay until `tx_busy_i` = 1, then go to `S_WAIT_DONE`. This state prevents a double launch while the transmitter's registered busy flag is still low.
- `S_WAIT_DONE`: stay while `tx_busy_i` = 1. When it drops, go to `S_IDLE`.

Output decoding:
- `tx_write_en_o` is a decode of state == `S_LAUNCH`. It has no other source.

Simultaneous events:
- A push and a pop in the same cycle are both performed, and `level_o` is unchanged.
- A push into an empty FIFO is not visible to the FSM until the next cycle. There is no bypass path.

Reset (asserted at any time, including mid-frame):
- Pointers are cleared and contents are discarded.
- FSM returns to `S_IDLE`.
- Reset output values: `tx_write_en_o` 0, `tx_byte_o` 8'h00, `full_o` 0, `empty_o` 1, `level_o` 0, `overflow_o` 0.
- The transmitter shares `reset_i`, so no partial frame survives reset.

## Timing
- Push-to-launch latency into an empty FIFO with an idle transmitter: `wr_en_i` at cycle 0, pop at cycle 1, `tx_write_en_o` high in cycle 2.
- With the transmitter attached, `tx_busy_i` rises in cycle 3 and the FSM reaches `S_WAIT_DONE` in cycle 4.
- Back-to-back frames: the next launch occurs 2 cycles after `tx_busy_i` falls (one cycle in `S_IDLE`, then `S_LAUNCH`).
- Flags and level update on the clock edge following the push or pop.

## Configuration
Macro: `UART_TX_FIFO_OVERFLOW_EN`.
- Defined:
  - Ports `overflow_o` and `ovf_clr_i` exist.
  - `overflow_o` is a sticky flag, set on the edge following any dropped push.
  - It is cleared by `ovf_clr_i` (sampled high) or by reset.
  - If a set and a clear occur in the same cycle, the set wins.
- Not defined:
  - Neither port exists.
  - Dropped pushes are silent.
  - No flag logic is synthesized.

## Structure
- Shared package `uart_pkg` holds:
  - `typedef enum logic [1:0] tx_fifo_state_e {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE}`
  - `localparam UART_FIFO_DEPTH_DEFAULT = 16`
- Sub-module `uart_fifo_ram`: parameterized `DEPTH` × 8 storage with synchronous write and asynchronous read. It is reused by the future RX FIFO.
- This block instantiates `uart_fifo_ram` and contains the pointers, flags, and drain FSM.

## Test plan
The bench instantiates `uart_tx_fifo` with `DEPTH` = 4, connected to the transmitter with `CLK_DIV_FACTOR` = 3.

1. Reset, then push 8'hA5 → `tx_write_en_o` pulses exactly 1 cycle, 2 cycles after the push, with `tx_byte_o` = 8'hA5. The line shows start bit, bits 1,0,1,0,0,1,0,1 LSB-first, then stop bit. `empty_o` returns to 1.
2. Push 8'h01, 8'h02, 8'h03 on consecutive cycles → three frames are emitted in order. Exactly one `tx_write_en_o` pulse per frame. No pulse while `tx_busy_i` = 1.
3. Hold the transmitter busy (force `tx_busy_i` = 1) and push 5 bytes → `full_o` = 1 and `level_o` = 4 after 4 pushes. The 5th byte is dropped. With the macro defined, `overflow_o` = 1 until `ovf_clr_i` is pulsed.
4. Repeat fill/drain 3 times with `DEPTH` = 4 (12 bytes) → the pointers wrap and the output sequence exactly equals the input sequence.
5. With the FIFO at `level_o` = 2, push in the same cycle as the pop in `S_IDLE` → `level_o` remains 2.
6. Assert `reset_i` mid-frame during a data bit → on the next edge `level_o` = 0, `empty_o` = 1, `tx_write_en_o` = 0, FSM is in `S_IDLE`, and no further frames are launched.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FIFO drain-FSM states and the default FIFO depth.
package uart_pkg;

  localparam int unsigned UART_FIFO_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_fifo_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 byte storage with synchronous write and asynchronous read.
// Shared by the UART TX and RX FIFOs.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  // Contents need no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter through its write_en/byte/busy handshake.
// Optional sticky overflow flag: define UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH_DEFAULT,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [7:0]       wr_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  output logic             tx_write_en_o,
  output logic [7:0]       tx_byte_o,
  input  logic             tx_busy_i
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic             overflow_o,
  input  logic             ovf_clr_i
`endif
);

  localparam int unsigned AW = LVL_W - 1;

  tx_fifo_state_e   state_q, state_d;
  logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       rd_data;
  logic             push, pop, full, empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // Drain FSM: WAIT_BUSY holds off a second launch until busy is seen high.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !tx_busy_i) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy_i) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Pointer and output-byte next state; full gates pushes using pre-edge state.
  always_comb begin
    push      = wr_en_i && !full;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tx_byte_d = tx_byte_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + LVL_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + LVL_W'(1);
      tx_byte_d = rd_data;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_byte_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign full_o        = full;
  assign empty_o       = empty;
  assign level_o       = wr_ptr_q - rd_ptr_q;
  assign tx_byte_o     = tx_byte_q;
  assign tx_write_en_o = (state_q == S_LAUNCH);

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // A dropped push in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end
    if (wr_en_i && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;
`endif

endmodule
